// File: rtl/pc_sequencer_if.sv
// Decoder-to-sequencer bundle: command pulses and immediates in, fetch address and status out.
// The sequencer attaches to the slave modport; the decoder side uses master.
interface pc_sequencer_if #(
    parameter int PC_W        = 16,
    parameter int BR_IMM_W    = 6,
    parameter int J_IMM_W     = 12,
    parameter int STACK_DEPTH = 4
);
    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

    logic                i_clk_en;
    logic                i_branch_taken;
    logic [BR_IMM_W-1:0] i_branch_imm;
    logic                i_jump_taken;
    logic                i_jump_link;
    logic [J_IMM_W-1:0]  i_jump_imm;
    logic                i_return_cmd;
    logic                i_halt_cmd;
    logic                i_int_enable_cmd;
    logic                i_int_disable_cmd;
    logic                i_int_trigger_cmd;
    logic                i_ext_irq;
    logic                i_resume;
    logic [PC_W-1:0]     o_pc;
    logic                o_halted;
    logic                o_in_isr;
    logic                o_int_enabled;
    logic [CNT_W-1:0]    o_stack_count;
    logic                o_stack_overflow;
    logic                o_stack_underflow;

    modport master (
        output i_clk_en, i_branch_taken, i_branch_imm, i_jump_taken, i_jump_link,
               i_jump_imm, i_return_cmd, i_halt_cmd, i_int_enable_cmd,
               i_int_disable_cmd, i_int_trigger_cmd, i_ext_irq, i_resume,
        input  o_pc, o_halted, o_in_isr, o_int_enabled, o_stack_count,
               o_stack_overflow, o_stack_underflow
    );

    modport slave (
        input  i_clk_en, i_branch_taken, i_branch_imm, i_jump_taken, i_jump_link,
               i_jump_imm, i_return_cmd, i_halt_cmd, i_int_enable_cmd,
               i_int_disable_cmd, i_int_trigger_cmd, i_ext_irq, i_resume,
        output o_pc, o_halted, o_in_isr, o_int_enabled, o_stack_count,
               o_stack_overflow, o_stack_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-fetch-address sequencer with circular link stack shared by JL/RETURN and
// interrupt entry, plus a RUN/HALTED/ISR state machine.
module pc_sequencer #(
    parameter int              PC_W         = 16,
    parameter int              BR_IMM_W     = 6,
    parameter int              J_IMM_W      = 12,
    parameter int              STACK_DEPTH  = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter logic [PC_W-1:0] INT_VECTOR   = 'h0010
) (
    input  logic             clk,
    input  logic             reset,
    pc_sequencer_if.slave    bus
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALTED = 2'd1, ST_ISR = 2'd2} state_t;

    state_t           r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic             r_int_en, w_int_en_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_unf, w_unf_nxt;
    logic [PC_W-1:0]  r_stack [STACK_DEPTH];

    logic [PC_W-1:0]  w_seq, w_br_tgt, w_j_tgt, w_pop_val, w_flow_nxt;
    logic             w_do_ret, w_do_jl, w_do_j, w_do_br, w_do_halt, w_pend;
    logic             w_wr1_en, w_wr2_en;
    logic [PTR_W-1:0] w_wr1_addr, w_wr2_addr;
    logic [PC_W-1:0]  w_wr2_data;
    logic [STACK_DEPTH-1:0] w_we1, w_we2;

    // Immediates are word offsets: sign-extend, then shift left by one.
    assign w_seq    = r_pc + PC_W'(2);
    assign w_br_tgt = w_seq + {{(PC_W-BR_IMM_W-1){bus.i_branch_imm[BR_IMM_W-1]}}, bus.i_branch_imm, 1'b0};
    assign w_j_tgt  = w_seq + {{(PC_W-J_IMM_W-1){bus.i_jump_imm[J_IMM_W-1]}}, bus.i_jump_imm, 1'b0};
    assign w_pop_val = (r_cnt == '0) ? w_seq : r_stack[r_ptr - PTR_W'(1)];

    assign w_do_ret  = bus.i_return_cmd;
    assign w_do_jl   = !w_do_ret && bus.i_jump_link;
    assign w_do_j    = !w_do_ret && !bus.i_jump_link && bus.i_jump_taken;
    assign w_do_br   = !w_do_ret && !bus.i_jump_link && !bus.i_jump_taken && bus.i_branch_taken;
    assign w_do_halt = !w_do_ret && !bus.i_jump_link && !bus.i_jump_taken && !bus.i_branch_taken
                       && bus.i_halt_cmd;
    assign w_pend    = r_int_en && (bus.i_ext_irq || bus.i_int_trigger_cmd) && (r_state != ST_ISR);

    assign w_flow_nxt = w_do_ret ? w_pop_val :
                        (w_do_jl || w_do_j) ? w_j_tgt :
                        w_do_br ? w_br_tgt : w_seq;

    // Up to two stack operations per cycle: the instruction's own push/pop,
    // followed by the interrupt-entry push landing on the updated pointer.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_int_en_nxt = bus.i_int_disable_cmd ? 1'b0 : (bus.i_int_enable_cmd ? 1'b1 : r_int_en);
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_ovf_nxt    = r_ovf;
        w_unf_nxt    = r_unf;
        w_wr1_en     = 1'b0;
        w_wr1_addr   = r_ptr;
        w_wr2_en     = 1'b0;
        w_wr2_addr   = r_ptr;
        w_wr2_data   = w_flow_nxt;
        case (r_state)
            ST_RUN, ST_ISR: begin
                if (w_do_ret) begin
                    if (r_cnt == '0) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr - PTR_W'(1);
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end else if (w_do_jl) begin
                    w_wr1_en  = 1'b1;
                    w_ptr_nxt = r_ptr + PTR_W'(1);
                    if (r_cnt == FULL) w_ovf_nxt = 1'b1;
                    else               w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (w_pend) begin
                    w_wr2_en    = 1'b1;
                    w_wr2_addr  = w_ptr_nxt;
                    w_ptr_nxt   = w_ptr_nxt + PTR_W'(1);
                    if (w_cnt_nxt == FULL) w_ovf_nxt = 1'b1;
                    else                   w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
                    w_pc_nxt    = INT_VECTOR;
                    w_state_nxt = ST_ISR;
                end else if (w_do_halt) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_pc_nxt = w_flow_nxt;
                    if (w_do_ret) w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (w_pend) begin
                    w_wr2_en    = 1'b1;
                    w_wr2_data  = w_seq;
                    w_ptr_nxt   = r_ptr + PTR_W'(1);
                    if (r_cnt == FULL) w_ovf_nxt = 1'b1;
                    else               w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_pc_nxt    = INT_VECTOR;
                    w_state_nxt = ST_ISR;
                end else if (bus.i_resume) begin
                    w_pc_nxt    = w_seq;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_VECTOR;
            r_int_en <= 1'b0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (bus.i_clk_en) begin
            r_state  <= w_state_nxt;
            r_pc     <= {w_pc_nxt[PC_W-1:1], 1'b0};
            r_int_en <= w_int_en_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
        end
    end

    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_we
        assign w_we1[gi] = w_wr1_en && (w_wr1_addr == PTR_W'(gi));
        assign w_we2[gi] = w_wr2_en && (w_wr2_addr == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.i_clk_en) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (w_we2[i])      r_stack[i] <= w_wr2_data;
                else if (w_we1[i]) r_stack[i] <= w_seq;
            end
        end
    end

    assign bus.o_pc              = r_pc;
    assign bus.o_halted          = (r_state == ST_HALTED);
    assign bus.o_in_isr          = (r_state == ST_ISR);
    assign bus.o_int_enabled     = r_int_en;
    assign bus.o_stack_count     = r_cnt;
    assign bus.o_stack_overflow  = r_ovf;
    assign bus.o_stack_underflow = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences,
// then random commands checked against a queue-based reference model.
module tb_pc_sequencer;
    localparam int PC_W = 16, BR_IMM_W = 6, J_IMM_W = 12, DEPTH = 4;
    localparam logic [15:0] RV = 16'h0000, IV = 16'h0010;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W), .BR_IMM_W(BR_IMM_W), .J_IMM_W(J_IMM_W), .STACK_DEPTH(DEPTH)) bus ();

    pc_sequencer #(.PC_W(PC_W), .BR_IMM_W(BR_IMM_W), .J_IMM_W(J_IMM_W), .STACK_DEPTH(DEPTH),
                   .RESET_VECTOR(RV), .INT_VECTOR(IV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit rst, en, br, j, jl, ret, hlt, ie, id, trig, irq, res;
        logic [5:0]  bimm;
        logic [11:0] jimm;
    } stim_t;

    typedef enum {C_NONE, C_HOLD, C_RST, C_BR, C_J, C_JL, C_RET, C_HALT, C_IE, C_IRQ, C_RES} code_t;

    typedef struct {
        code_t       code;
        int          imm;
        logic [15:0] e_pc;
        int          e_cnt;
        logic [4:0]  e_f;   // {halted, in_isr, int_enabled, overflow, underflow}
    } vec_t;

    vec_t vecs[$];

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.en = 1'b1;
        return s;
    endfunction

    function automatic stim_t from_code(code_t c, int imm);
        stim_t s;
        s = idle();
        case (c)
            C_HOLD: s.en  = 1'b0;
            C_RST:  s.rst = 1'b1;
            C_BR:   begin s.br = 1'b1; s.bimm = imm[5:0];  end
            C_J:    begin s.j  = 1'b1; s.jimm = imm[11:0]; end
            C_JL:   begin s.jl = 1'b1; s.jimm = imm[11:0]; end
            C_RET:  s.ret = 1'b1;
            C_HALT: s.hlt = 1'b1;
            C_IE:   s.ie  = 1'b1;
            C_IRQ:  s.irq = 1'b1;
            C_RES:  s.res = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    function void add(code_t c, int imm, logic [15:0] p, int n, logic [4:0] f);
        vec_t v;
        v.code = c; v.imm = imm; v.e_pc = p; v.e_cnt = n; v.e_f = f;
        vecs.push_back(v);
    endfunction

    task automatic drive(stim_t s);
        reset                 = s.rst;
        bus.i_clk_en          = s.en;
        bus.i_branch_taken    = s.br;
        bus.i_branch_imm      = s.bimm;
        bus.i_jump_taken      = s.j;
        bus.i_jump_link       = s.jl;
        bus.i_jump_imm        = s.jimm;
        bus.i_return_cmd      = s.ret;
        bus.i_halt_cmd        = s.hlt;
        bus.i_int_enable_cmd  = s.ie;
        bus.i_int_disable_cmd = s.id;
        bus.i_int_trigger_cmd = s.trig;
        bus.i_ext_irq         = s.irq;
        bus.i_resume          = s.res;
    endtask

    task automatic step(stim_t s);
        drive(s);
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [15:0] epc, int ecnt, logic [4:0] ef);
        logic [4:0] af;
        logic [2:0] ec;
        af = {bus.o_halted, bus.o_in_isr, bus.o_int_enabled, bus.o_stack_overflow, bus.o_stack_underflow};
        ec = 3'(ecnt);
        n_cmp++;
        if (bus.o_pc !== epc || bus.o_stack_count !== ec || af !== ef) begin
            n_bad++;
            $display("FAIL %s: got pc=%h cnt=%0d flags=%b, expected pc=%h cnt=%0d flags=%b",
                     name, bus.o_pc, bus.o_stack_count, af, epc, ecnt, ef);
        end else begin
            $display("ok   %s: pc=%h cnt=%0d flags=%b", name, bus.o_pc, bus.o_stack_count, af);
        end
    endtask

    // Reference model: stack as a bounded queue, state as two booleans.
    logic [15:0] m_pc;
    bit          m_halt, m_isr, m_ie, m_ovf, m_unf;
    logic [15:0] m_stk[$];

    task automatic m_push(logic [15:0] v);
        m_stk.push_back(v);
        if (m_stk.size() > DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    task automatic m_pop(logic [15:0] seq, output logic [15:0] v);
        if (m_stk.size() == 0) begin
            m_unf = 1'b1;
            v = seq;
        end else begin
            v = m_stk.pop_back();
        end
    endtask

    task automatic model_step(stim_t s);
        logic [15:0] seq, bt, jt, nxt;
        bit pend, ie_new;
        int boff, joff;
        if (s.rst) begin
            m_pc = RV; m_halt = 0; m_isr = 0; m_ie = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
            return;
        end
        if (!s.en) return;
        seq    = m_pc + 16'd2;
        boff   = $signed(s.bimm);
        joff   = $signed(s.jimm);
        bt     = 16'(int'(seq) + 2 * boff);
        jt     = 16'(int'(seq) + 2 * joff);
        pend   = m_ie && (s.irq || s.trig) && !m_isr;
        ie_new = s.id ? 1'b0 : (s.ie ? 1'b1 : m_ie);
        if (m_halt) begin
            if (pend) begin
                m_push(seq); m_pc = IV; m_halt = 0; m_isr = 1;
            end else if (s.res) begin
                m_pc = seq; m_halt = 0;
            end
        end else begin
            if (s.ret)      m_pop(seq, nxt);
            else if (s.jl)  begin m_push(seq); nxt = jt; end
            else if (s.j)   nxt = jt;
            else if (s.br)  nxt = bt;
            else            nxt = seq;
            if (pend) begin
                m_push(nxt); m_pc = IV; m_isr = 1;
            end else if (!s.ret && !s.jl && !s.j && !s.br && s.hlt) begin
                m_halt = 1; m_isr = 0;
            end else begin
                m_pc = nxt;
                if (s.ret) m_isr = 0;
            end
        end
        m_ie = ie_new;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s      = idle();
        s.rst  = ($urandom_range(0, 79) == 0);
        s.en   = ($urandom_range(0, 7) != 0);
        s.br   = ($urandom_range(0, 4) == 0);
        s.j    = ($urandom_range(0, 6) == 0);
        s.jl   = ($urandom_range(0, 4) == 0);
        s.ret  = ($urandom_range(0, 4) == 0);
        s.hlt  = ($urandom_range(0, 9) == 0);
        s.ie   = ($urandom_range(0, 3) == 0);
        s.id   = ($urandom_range(0, 11) == 0);
        s.trig = ($urandom_range(0, 11) == 0);
        s.irq  = ($urandom_range(0, 5) == 0);
        s.res  = ($urandom_range(0, 2) == 0);
        s.bimm = 6'($urandom);
        s.jimm = 12'($urandom);
        return s;
    endfunction

    initial begin
        stim_t s;
        drive(from_code(C_RST, 0));

        add(C_RST,  0,   16'h0000, 0, 5'b00000);
        add(C_NONE, 0,   16'h0002, 0, 5'b00000);
        add(C_NONE, 0,   16'h0004, 0, 5'b00000);
        add(C_NONE, 0,   16'h0006, 0, 5'b00000);
        add(C_NONE, 0,   16'h0008, 0, 5'b00000);
        add(C_HOLD, 0,   16'h0008, 0, 5'b00000);
        add(C_HOLD, 0,   16'h0008, 0, 5'b00000);
        add(C_J,    11,  16'h0020, 0, 5'b00000);
        add(C_BR,   62,  16'h001E, 0, 5'b00000);
        add(C_J,    4,   16'h0028, 0, 5'b00000);
        add(C_J,    11,  16'h0040, 0, 5'b00000);
        add(C_JL,   16,  16'h0062, 1, 5'b00000);
        add(C_RET,  0,   16'h0042, 0, 5'b00000);
        add(C_JL,   8,   16'h0054, 1, 5'b00000);
        add(C_JL,   8,   16'h0066, 2, 5'b00000);
        add(C_JL,   8,   16'h0078, 3, 5'b00000);
        add(C_JL,   8,   16'h008A, 4, 5'b00000);
        add(C_JL,   8,   16'h009C, 4, 5'b00010);
        add(C_RET,  0,   16'h008C, 3, 5'b00010);
        add(C_RET,  0,   16'h007A, 2, 5'b00010);
        add(C_RET,  0,   16'h0068, 1, 5'b00010);
        add(C_RET,  0,   16'h0056, 0, 5'b00010);
        add(C_RET,  0,   16'h0058, 0, 5'b00011);
        add(C_IE,   0,   16'h005A, 0, 5'b00111);
        add(C_J,    82,  16'h0100, 0, 5'b00111);
        add(C_IRQ,  0,   16'h0010, 1, 5'b01111);
        add(C_IRQ,  0,   16'h0012, 1, 5'b01111);
        add(C_RET,  0,   16'h0102, 0, 5'b00111);
        add(C_J,    126, 16'h0200, 0, 5'b00111);
        add(C_HALT, 0,   16'h0200, 0, 5'b10111);
        add(C_NONE, 0,   16'h0200, 0, 5'b10111);
        add(C_J,    5,   16'h0200, 0, 5'b10111);
        add(C_NONE, 0,   16'h0200, 0, 5'b10111);
        add(C_RES,  0,   16'h0202, 0, 5'b00111);
        add(C_IRQ,  0,   16'h0010, 1, 5'b01111);
        add(C_RST,  0,   16'h0000, 0, 5'b00000);
        add(C_J,    12'hFFE, 16'hFFFE, 0, 5'b00000);
        add(C_NONE, 0,   16'h0000, 0, 5'b00000);

        foreach (vecs[i]) begin
            step(from_code(vecs[i].code, vecs[i].imm));
            check($sformatf("vec%0d_%s", i, vecs[i].code.name()), vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_f);
        end

        // Enable and disable together: disable wins.
        s = idle(); s.ie = 1; s.id = 1;
        step(s); check("ie_id_same_cycle", 16'h0002, 0, 5'b00000);
        s = idle(); s.ie = 1;
        step(s); check("ie_set", 16'h0004, 0, 5'b00100);
        // JL and interrupt in the same cycle: two entries, return address then JL target.
        s = idle(); s.jl = 1; s.jimm = 12'h020; s.irq = 1;
        step(s); check("jl_plus_irq", 16'h0010, 2, 5'b01100);
        s = idle(); s.ret = 1;
        step(s); check("ret_to_jl_target", 16'h0046, 1, 5'b00100);
        s = idle(); s.ret = 1;
        step(s); check("ret_to_jl_link", 16'h0006, 0, 5'b00100);
        // HALT inside ISR drops ISR status; resume goes to RUN.
        s = idle(); s.irq = 1;
        step(s); check("irq_enter", 16'h0010, 1, 5'b01100);
        s = idle(); s.hlt = 1;
        step(s); check("halt_in_isr", 16'h0010, 1, 5'b10100);
        s = idle(); s.res = 1;
        step(s); check("resume_to_run", 16'h0012, 1, 5'b00100);
        // Software trigger while halted pushes pc + 2.
        s = idle(); s.hlt = 1;
        step(s); check("halt_again", 16'h0012, 1, 5'b10100);
        s = idle(); s.trig = 1;
        step(s); check("trig_from_halt", 16'h0010, 2, 5'b01100);
        s = idle(); s.ret = 1;
        step(s); check("ret_from_halt_isr", 16'h0014, 1, 5'b00100);

        for (int k = 0; k < 1200; k++) begin
            s = rand_stim();
            if (k == 0) s.rst = 1'b1;
            model_step(s);
            step(s);
            check($sformatf("rnd%0d", k), m_pc, m_stk.size(),
                  {m_halt, m_isr, m_ie, m_ovf, m_unf});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
